// File: rtl/vga_timing_gen.sv
// VGA raster generator: publishes DrawX/DrawY to the colour mapper and registers
// the returned colour together with sync/blank so all DAC pins share one pixel of latency.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pixel_ce,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, fs_q, fs_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       h_end, v_end, visible;

    always_comb begin
        h_end   = (hcnt_q == H_MAX);
        v_end   = (vcnt_q == V_MAX);
        visible = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);

        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        fs_d      = 1'b0;

        if (pixel_ce) begin
            hcnt_d = h_end ? 10'd0 : hcnt_q + 10'd1;
            if (h_end)
                vcnt_d = v_end ? 10'd0 : vcnt_q + 10'd1;
            // Output stage looks at the pre-increment count, i.e. the pixel the mapper just coloured.
            hs_d      = ~((hcnt_q >= HS_LO) && (hcnt_q <= HS_HI));
            vs_d      = ~((vcnt_q >= VS_LO) && (vcnt_q <= VS_HI));
            blank_n_d = visible;
            r_d       = visible ? Red_in   : 8'd0;
            g_d       = visible ? Green_in : 8'd0;
            b_d       = visible ? Blue_in  : 8'd0;
            fs_d      = h_end && v_end;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
            fs_q      <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            fs_q      <= fs_d;
        end
    end

    assign DrawX       = hcnt_q;
    assign DrawY       = vcnt_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level checks and a shrunk
// instance for whole-frame checks, both compared against a pixel-index reference model.
module tb_vga_timing_gen;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       pixel_ce;
    logic [7:0] redA, greenA, redB, greenB;

    logic [9:0] dxA, dyA, dxB, dyB;
    logic       hsA, vsA, bnA, fsA, hsB, vsB, bnB, fsB;
    logic [7:0] rA, gA, bA, rB, gB, bB;

    int tests = 0;
    int fails = 0;

    // Model state: ce-pixels since reset and inputs captured at the last ce edge.
    int unsigned pixA, pixB;
    logic [7:0]  lrA, lgA, lrB, lgB;
    logic        fsExpA, fsExpB;

    always #5 Clk = ~Clk;

    vga_timing_gen dutA (
        .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce),
        .Red_in(redA), .Green_in(greenA), .Blue_in(dxA[7:0]),
        .DrawX(dxA), .DrawY(dyA), .VGA_HS(hsA), .VGA_VS(vsA), .VGA_BLANK_N(bnA),
        .VGA_R(rA), .VGA_G(gA), .VGA_B(bA), .frame_start(fsA)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dutB (
        .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce),
        .Red_in(redB), .Green_in(greenB), .Blue_in(dxB[7:0]),
        .DrawX(dxB), .DrawY(dyB), .VGA_HS(hsB), .VGA_VS(vsB), .VGA_BLANK_N(bnB),
        .VGA_R(rB), .VGA_G(gB), .VGA_B(bB), .frame_start(fsB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(
        input string nm, input int unsigned pix, input logic fs_exp,
        input int hv, input int hf, input int hsy, input int hb,
        input int vv, input int vf, input int vsy, input int vb,
        input logic [7:0] lr, input logic [7:0] lg,
        input logic [9:0] dx, input logic [9:0] dy, input logic hs, input logic vs,
        input logic bn, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
        input logic fs);
        int unsigned ht, vt, p, px, py;
        logic vis, e_hs, e_vs;
        logic [7:0] e_b;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        chk({nm, ".DrawX"}, 32'(dx), pix % ht);
        chk({nm, ".DrawY"}, 32'(dy), (pix / ht) % vt);
        chk({nm, ".frame_start"}, 32'(fs), 32'(fs_exp));
        if (pix == 0) begin
            vis = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_b = 8'd0;
        end else begin
            p  = pix - 1;
            px = p % ht;
            py = (p / ht) % vt;
            vis  = (px < hv) && (py < vv);
            e_hs = !((px >= hv + hf) && (px < hv + hf + hsy));
            e_vs = !((py >= vv + vf) && (py < vv + vf + vsy));
            e_b  = vis ? px[7:0] : 8'd0;
        end
        chk({nm, ".VGA_HS"}, 32'(hs), 32'(e_hs));
        chk({nm, ".VGA_VS"}, 32'(vs), 32'(e_vs));
        chk({nm, ".BLANK_N"}, 32'(bn), 32'(vis));
        chk({nm, ".VGA_R"}, 32'(r), vis ? 32'(lr) : 32'd0);
        chk({nm, ".VGA_G"}, 32'(g), vis ? 32'(lg) : 32'd0);
        chk({nm, ".VGA_B"}, 32'(b), 32'(e_b));
    endtask

    task automatic check_all();
        check_inst("A", pixA, fsExpA, 640, 16, 96, 48, 480, 10, 2, 33, lrA, lgA,
                   dxA, dyA, hsA, vsA, bnA, rA, gA, bA, fsA);
        check_inst("B", pixB, fsExpB, 16, 4, 6, 6, 8, 2, 2, 3, lrB, lgB,
                   dxB, dyB, hsB, vsB, bnB, rB, gB, bB, fsB);
    endtask

    // One Clk with the given enable; colour inputs change every clock.
    task automatic step(input logic ce, input logic red_ff);
        pixel_ce = ce;
        redA   = red_ff ? 8'hff : 8'($urandom);
        greenA = 8'($urandom);
        redB   = 8'($urandom);
        greenB = 8'($urandom);
        @(posedge Clk);
        #1;
        fsExpA = 1'b0;
        fsExpB = 1'b0;
        if (ce) begin
            pixA++; pixB++;
            lrA = redA; lgA = greenA; lrB = redB; lgB = greenB;
            fsExpA = (pixA % (800 * 525)) == 0;
            fsExpB = (pixB % (32 * 15)) == 0;
        end
        check_all();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        pixA = 0; pixB = 0; fsExpA = 1'b0; fsExpB = 1'b0;
        check_all();
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        Reset = 1'b0;
    endtask

    initial begin
        int vis_ff, r_other, hs_low, first_hs_dx, prev_dx;
        int pulses, since, span, vs_low, steps;
        logic [9:0] sdx;
        logic       shs, sbn;
        logic [7:0] sr;

        Reset = 1'b1; pixel_ce = 1'b0;
        redA = 0; greenA = 0; redB = 0; greenB = 0;
        lrA = 0; lgA = 0; lrB = 0; lgB = 0;
        pixA = 0; pixB = 0; fsExpA = 0; fsExpB = 0;
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        Reset = 1'b0;

        // Enable toggling, then a long stall where nothing may move.
        step(1, 0); chk("ce_step1", 32'(dxA), 32'd1);
        step(0, 0); chk("ce_hold1", 32'(dxA), 32'd1);
        step(1, 0); chk("ce_step2", 32'(dxA), 32'd2);
        step(0, 0);
        sdx = dxA; shs = hsA; sbn = bnA; sr = rA;
        for (int i = 0; i < 10; i++) step(0, 0);
        chk("stall_dx", 32'(dxA), 32'(sdx));
        chk("stall_out", {21'd0, shs, sbn, sr}, {21'd0, hsA, bnA, rA});

        // One full line on the full-size instance with constant red.
        do_reset();
        vis_ff = 0; r_other = 0; hs_low = 0; first_hs_dx = -1;
        for (int i = 0; i < 800; i++) begin
            prev_dx = int'(dxA);
            step(1, 1);
            if (bnA && rA == 8'hff) vis_ff++;
            if (!bnA && rA != 8'd0) r_other++;
            if (!hsA) begin
                if (hs_low == 0) first_hs_dx = prev_dx;
                hs_low++;
            end
        end
        chk("line_visible_ff", 32'(vis_ff), 32'd640);
        chk("line_r_blanked", 32'(r_other), 32'd0);
        chk("line_hs_low", 32'(hs_low), 32'd96);
        chk("line_hs_first", 32'(first_hs_dx), 32'd656);

        // Advance mid-line, then reset asynchronously between clock edges.
        for (int i = 0; i < 300; i++) step(1, 0);
        chk("pre_reset_dx", 32'(dxA), 32'd300);
        #2;
        do_reset();
        step(1, 0);
        chk("resume_dx", 32'(dxA), 32'd1);

        // Random enables across two full frames of the shrunk instance.
        pulses = 0; since = 0; span = 0; vs_low = 0; steps = 0;
        while (pulses < 3 && steps < 6000) begin
            logic ce;
            ce = ($urandom_range(0, 3) != 0);
            step(ce, 0);
            steps++;
            if (ce) begin
                since++;
                if (pulses == 1 && !vsB) vs_low++;
            end
            if (fsB) begin
                if (pulses == 1) span = since;
                pulses++;
                since = 0;
            end
        end
        chk("frame_pulses", 32'(pulses), 32'd3);
        chk("frame_span", 32'(span), 32'd480);
        chk("frame_vs_low", 32'(vs_low), 32'd64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
